// File: rtl/csr_io_responder.sv
// CSR/MMIO responder: 64-bit cycle counter with coherent high-word snapshot,
// scratch register, baud divisor and an 8N1 UART transmitter with IO-busy flag.
module csr_io_responder #(
  parameter logic [15:0] DEFAULT_BAUD_DIV = 16'd867,
  parameter logic [31:0] SCRATCH_RESET    = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IN_ce,
  input  logic        IN_we,
  input  logic [29:0] IN_addr,
  input  logic [31:0] IN_wdata,
  input  logic [3:0]  IN_wm,
  output logic [31:0] OUT_rdata,
  output logic        OUT_busy,
  output logic        OUT_tx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_e;

  localparam logic [2:0] A_CYC_LO  = 3'd0;
  localparam logic [2:0] A_CYC_HI  = 3'd1;
  localparam logic [2:0] A_SCRATCH = 3'd2;
  localparam logic [2:0] A_TX      = 3'd3;
  localparam logic [2:0] A_BAUD    = 3'd4;

  logic [63:0] cycle_q,   cycle_d;
  logic [31:0] hi_snap_q, hi_snap_d;
  logic [31:0] scratch_q, scratch_d;
  logic [15:0] baud_q,    baud_d;
  logic        ovf_q,     ovf_d;
  logic [31:0] rdata_q,   rdata_d;

  tx_state_e   state_q,   state_d;
  logic [15:0] bit_cnt_q, bit_cnt_d;
  logic [15:0] div_lat_q, div_lat_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shreg_q,   shreg_d;
  logic        tx_q,      tx_d;
  logic        busy_q,    busy_d;

  logic        rd_en;
  logic        wr_en;
  logic [2:0]  reg_sel;
  logic        bit_end;
  logic        frame_done;
  logic        tx_req;
  logic        tx_accept;
  logic        tx_drop;
  logic        unused_addr_hi;

  assign rd_en          = !IN_ce && IN_we;
  assign wr_en          = !IN_ce && !IN_we;
  assign reg_sel        = IN_addr[2:0];
  assign unused_addr_hi = ^IN_addr[29:3];

  assign bit_end    = (bit_cnt_q == div_lat_q);
  // The stop bit's last cycle counts as idle so a back-to-back byte is
  // accepted on the very edge at which busy drops.
  assign frame_done = (state_q == S_STOP) && bit_end;
  assign tx_req     = wr_en && (reg_sel == A_TX) && IN_wm[0];
  assign tx_accept  = tx_req && (!busy_q || frame_done);
  assign tx_drop    = tx_req && busy_q && !frame_done;

  always_comb begin
    cycle_d   = cycle_q + 64'd1;
    hi_snap_d = hi_snap_q;
    scratch_d = scratch_q;
    baud_d    = baud_q;
    rdata_d   = rdata_q;
    ovf_d     = ovf_q;

    if (rd_en) begin
      unique case (reg_sel)
        A_CYC_LO: begin
          rdata_d   = cycle_q[31:0];
          hi_snap_d = cycle_q[63:32];
        end
        A_CYC_HI:  rdata_d = hi_snap_q;
        A_SCRATCH: rdata_d = scratch_q;
        A_TX: begin
          rdata_d = {30'b0, ovf_q, busy_q};
          ovf_d   = 1'b0;
        end
        A_BAUD:    rdata_d = {16'b0, baud_q};
        default:   rdata_d = '0;
      endcase
    end

    if (wr_en && (reg_sel == A_SCRATCH)) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (IN_wm[i]) scratch_d[i*8 +: 8] = IN_wdata[i*8 +: 8];
      end
    end

    if (wr_en && (reg_sel == A_BAUD)) begin
      if (IN_wm[0]) baud_d[7:0]  = IN_wdata[7:0];
      if (IN_wm[1]) baud_d[15:8] = IN_wdata[15:8];
    end

    if (tx_drop) ovf_d = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    div_lat_d = div_lat_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;

    unique case (state_q)
      S_IDLE: tx_d = 1'b1;
      S_START: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          tx_d      = shreg_q[0];
          state_d   = S_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shreg_d   = {1'b0, shreg_q[7:1]};
            tx_d      = shreg_q[1];
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          tx_d      = 1'b1;
          state_d   = S_IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    if (tx_accept) begin
      state_d   = S_START;
      bit_cnt_d = '0;
      bit_idx_d = '0;
      div_lat_d = baud_q;
      shreg_d   = IN_wdata[7:0];
      tx_d      = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      hi_snap_q <= '0;
      scratch_q <= SCRATCH_RESET;
      baud_q    <= DEFAULT_BAUD_DIV;
      ovf_q     <= 1'b0;
      rdata_q   <= '0;
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      div_lat_q <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      cycle_q   <= cycle_d;
      hi_snap_q <= hi_snap_d;
      scratch_q <= scratch_d;
      baud_q    <= baud_d;
      ovf_q     <= ovf_d;
      rdata_q   <= rdata_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      div_lat_q <= div_lat_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign OUT_rdata = rdata_q;
  assign OUT_busy  = busy_q;
  assign OUT_tx    = tx_q;

endmodule

// File: tb/tb_csr_io_responder.sv
// Directed and random bench for csr_io_responder; the UART is modelled as a
// frame start time plus a bit table rather than a state machine.
module tb_csr_io_responder;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic        we;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wm;
  logic [31:0] OUT_rdata;
  logic        OUT_busy;
  logic        OUT_tx;

  csr_io_responder #(
    .DEFAULT_BAUD_DIV(16'd867),
    .SCRATCH_RESET   (32'h0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .IN_ce    (ce),
    .IN_we    (we),
    .IN_addr  (addr),
    .IN_wdata (wdata),
    .IN_wm    (wm),
    .OUT_rdata(OUT_rdata),
    .OUT_busy (OUT_busy),
    .OUT_tx   (OUT_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  longint unsigned mcyc;
  logic [31:0]     m_hi, m_scr, m_rd;
  logic [15:0]     m_baud;
  bit              m_ovf;
  bit              f_act;
  int              f_n, f_p;
  logic [7:0]      f_byte;
  int              now;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic mreset();
    mcyc   = 0;
    m_hi   = '0;
    m_scr  = 32'h0;
    m_rd   = '0;
    m_baud = 16'd867;
    m_ovf  = 0;
    f_act  = 0;
    f_n    = 0;
    f_p    = 1;
    f_byte = '0;
    now    = 0;
  endtask

  // Output state after edge t: busy while fewer than 10 bit periods have elapsed.
  function automatic bit mbusy(input int t);
    return f_act && ((t - f_n) < 10 * f_p);
  endfunction

  function automatic bit mtx(input int t);
    int j;
    if (!mbusy(t)) return 1'b1;
    j = (t - f_n) / f_p;
    if (j == 0) return 1'b0;
    if (j <= 8) return f_byte[j-1];
    return 1'b1;
  endfunction

  task automatic tick();
    int m;
    m = now + 1;
    if (!ce && we) begin
      case (addr[2:0])
        3'd0: begin m_rd = mcyc[31:0]; m_hi = mcyc[63:32]; end
        3'd1: m_rd = m_hi;
        3'd2: m_rd = m_scr;
        3'd3: begin m_rd = {30'b0, m_ovf, mbusy(now)}; m_ovf = 0; end
        3'd4: m_rd = {16'b0, m_baud};
        default: m_rd = '0;
      endcase
    end else if (!ce && !we) begin
      case (addr[2:0])
        3'd2: for (int i = 0; i < 4; i++) if (wm[i]) m_scr[i*8 +: 8] = wdata[i*8 +: 8];
        3'd3: if (wm[0]) begin
          if (mbusy(m)) m_ovf = 1;
          else begin
            f_act  = 1;
            f_n    = m;
            f_p    = int'(m_baud) + 1;
            f_byte = wdata[7:0];
          end
        end
        3'd4: begin
          if (wm[0]) m_baud[7:0]  = wdata[7:0];
          if (wm[1]) m_baud[15:8] = wdata[15:8];
        end
        default: ;
      endcase
    end
    mcyc++;
    now = m;
    @(posedge clk);
    #1;
    check("rdata", {32'b0, OUT_rdata}, {32'b0, m_rd});
    check("busy", {63'b0, OUT_busy}, {63'b0, mbusy(now)});
    check("tx", {63'b0, OUT_tx}, {63'b0, mtx(now)});
    ce = 1'b1;
    we = 1'b1;
    wm = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rd(input logic [2:0] a);
    ce = 1'b0; we = 1'b1; addr = {27'b0, a};
    tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] m);
    ce = 1'b0; we = 1'b0; addr = {27'b0, a}; wdata = d; wm = m;
    tick();
  endtask

  initial begin
    logic [9:0] pat;
    int         busy_cnt;
    int         r;

    rst_n = 1'b0; ce = 1'b1; we = 1'b1; addr = '0; wdata = '0; wm = '0;
    mreset();
    #23;
    check("reset_rdata", {32'b0, OUT_rdata}, 64'h0);
    check("reset_busy", {63'b0, OUT_busy}, 64'h0);
    check("reset_tx", {63'b0, OUT_tx}, 64'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // cycle counter read after five idle cycles, then the snapshot high word
    idle(5);
    rd(3'd0);
    check("cyc_lo_5", {32'b0, OUT_rdata}, 64'd5);
    rd(3'd1);
    check("cyc_hi_0", {32'b0, OUT_rdata}, 64'd0);
    rd(3'd4);
    check("baud_reset", {32'b0, OUT_rdata}, 64'd867);

    // scratch byte masking
    wr(3'd2, 32'hAABBCCDD, 4'hF);
    wr(3'd2, 32'h00001100, 4'b0010);
    rd(3'd2);
    check("scratch_mask", {32'b0, OUT_rdata}, 64'hAABB11DD);

    // BAUD_DIV=1, transmit 0xA5
    wr(3'd4, 32'h1, 4'h3);
    pat = 10'b1101001010;
    busy_cnt = 0;
    wr(3'd3, 32'hA5, 4'h1);
    for (int i = 0; i < 25; i++) begin
      if (i < 20) check("a5_bit", {63'b0, OUT_tx}, {63'b0, pat[i/2]});
      if (OUT_busy) busy_cnt++;
      if (i < 24) tick();
    end
    check("a5_busy_len", 64'(busy_cnt), 64'd20);

    // overrun: second byte dropped, ovf reported once
    wr(3'd3, 32'h5A, 4'h1);
    tick();
    wr(3'd3, 32'h3C, 4'h1);
    rd(3'd3);
    check("ovf_read1", {32'b0, OUT_rdata}, 64'h3);
    rd(3'd3);
    check("ovf_read2", {32'b0, OUT_rdata}, 64'h1);
    idle(20);

    // carry between LO and HI reads must not tear the pair
    force dut.cycle_q = 64'h0000_0001_FFFF_FFFF;
    #1 release dut.cycle_q;
    mcyc = 64'h0000_0001_FFFF_FFFF;
    rd(3'd0);
    check("carry_lo", {32'b0, OUT_rdata}, 64'hFFFF_FFFF);
    rd(3'd1);
    check("carry_hi", {32'b0, OUT_rdata}, 64'h1);
    rd(3'd0);
    rd(3'd1);
    check("carry_hi_after", {32'b0, OUT_rdata}, 64'h2);

    // random traffic against the model
    for (int k = 0; k < 800; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4) tick();
      else if (r < 7) rd(3'($urandom_range(0, 7)));
      else begin
        logic [2:0] a;
        logic [31:0] d;
        a = 3'($urandom_range(0, 7));
        d = (a == 3'd4) ? 32'($urandom_range(0, 3)) : $urandom;
        wr(a, d, 4'($urandom_range(0, 15)));
      end
    end
    idle(50);

    // asynchronous reset in the middle of a data bit
    wr(3'd4, 32'h3, 4'h3);
    wr(3'd3, 32'h81, 4'h1);
    idle(14);
    check("pre_abort_busy", {63'b0, OUT_busy}, 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {63'b0, OUT_busy}, 64'h0);
    check("abort_tx", {63'b0, OUT_tx}, 64'h1);
    check("abort_rdata", {32'b0, OUT_rdata}, 64'h0);
    mreset();
    #2 rst_n = 1'b1;
    idle(10);
    wr(3'd4, 32'h0, 4'h3);
    wr(3'd3, 32'h96, 4'h1);
    idle(12);
    rd(3'd3);
    check("post_abort_status", {32'b0, OUT_rdata}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
